// File: rtl/mc_ctrl_fsm_if.sv
// Control-unit <-> datapath/memory bundle for the multi-cycle RV32I core.
// The slave side is the control FSM; the master side is the datapath driving the IR fields.
interface mc_ctrl_fsm_if;
    logic       run, func7_5, br_taken, mem_ready;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       ifetch, ir_write, pc_write, regwrite;
    logic [1:0] alusrc1, alusrc2, pcsrc;
    logic [5:0] aluop;
    logic       memread, memwrite, mem2reg, illegal;
    logic [2:0] memop, state;

    modport slave (
        input  run, opcode, func3, func7_5, br_taken, mem_ready,
        output ifetch, ir_write, pc_write, regwrite, alusrc1, alusrc2, aluop,
               memread, memwrite, memop, mem2reg, pcsrc, state, illegal
    );
    modport master (
        output run, opcode, func3, func7_5, br_taken, mem_ready,
        input  ifetch, ir_write, pc_write, regwrite, alusrc1, alusrc2, aluop,
               memread, memwrite, memop, mem2reg, pcsrc, state, illegal
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control unit: sequences IF/ID/EX/MEM/WB and decodes datapath
// controls from the current state and the held IR fields.
module mc_ctrl_fsm #(
    parameter int USE_READY = 1,
    parameter int MEM_LAT   = 2,
    parameter int CNT_W     = 4
) (
    input  logic         clk,
    input  logic         rstn,
    mc_ctrl_fsm_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_IF = 3'd1, S_ID = 3'd2, S_EX = 3'd3,
        S_MEM  = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_RI     = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LAT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             done, in_wait, legal, is_ld, is_st, is_br;

    assign is_ld   = (bus.opcode == OP_LOAD);
    assign is_st   = (bus.opcode == OP_STORE);
    assign is_br   = (bus.opcode == OP_BRANCH);
    assign in_wait = (state_q == S_IF) || (state_q == S_MEM);
    // Completion of the current IF/MEM access; only meaningful while in_wait.
    assign done    = (USE_READY != 0) ? bus.mem_ready : (cnt_q == LAST);

    always_comb begin
        case (bus.opcode)
            OP_R, OP_RI, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_AUIPC, OP_LUI: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            // Counter is zero outside a wait, so every entry into IF/MEM starts from 0.
            if (in_wait && !done && (USE_READY == 0)) cnt_q <= cnt_q + 1'b1;
            else                                      cnt_q <= '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.run) state_d = S_IF;
            S_IF:   if (done) state_d = S_ID;
            S_ID:   state_d = legal ? S_EX : S_TRAP;
            S_EX: begin
                if (is_ld || is_st) state_d = S_MEM;
                else if (is_br)     state_d = bus.run ? S_IF : S_IDLE;
                else                state_d = S_WB;
            end
            S_MEM: begin
                if (done) begin
                    if (is_ld) state_d = S_WB;
                    else       state_d = bus.run ? S_IF : S_IDLE;
                end
            end
            S_WB:   state_d = bus.run ? S_IF : S_IDLE;
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ifetch   = 1'b0;
        bus.ir_write = 1'b0;
        bus.pc_write = 1'b0;
        bus.regwrite = 1'b0;
        bus.alusrc1  = 2'b00;
        bus.alusrc2  = 2'b00;
        bus.aluop    = 6'b000000;
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        bus.memop    = 3'b000;
        bus.mem2reg  = 1'b0;
        bus.pcsrc    = 2'b00;
        case (state_q)
            S_IF: begin
                bus.ifetch   = 1'b1;
                bus.ir_write = done;
            end
            S_EX: begin
                case (bus.opcode)
                    OP_R: begin
                        bus.alusrc1 = 2'b10; bus.alusrc2 = 2'b10;
                        bus.aluop   = {2'b00, bus.func3, bus.func7_5};
                    end
                    OP_RI: begin
                        // func7_5 only distinguishes SRAI from SRLI; elsewhere it is immediate bits.
                        bus.alusrc1 = 2'b10; bus.alusrc2 = 2'b11;
                        bus.aluop   = {2'b00, bus.func3, (bus.func3 == 3'b101) & bus.func7_5};
                    end
                    OP_LOAD, OP_STORE: begin
                        bus.alusrc1 = 2'b10; bus.alusrc2 = 2'b11;
                    end
                    OP_BRANCH: begin
                        bus.alusrc1  = 2'b10; bus.alusrc2 = 2'b10;
                        bus.aluop    = {2'b01, bus.func3, 1'b0};
                        bus.pc_write = 1'b1;
                        bus.pcsrc    = bus.br_taken ? 2'b01 : 2'b00;
                    end
                    OP_JAL, OP_JALR: begin
                        bus.alusrc1 = 2'b11; bus.alusrc2 = 2'b01;
                        bus.aluop   = 6'b100000;
                    end
                    OP_AUIPC: begin
                        bus.alusrc1 = 2'b11; bus.alusrc2 = 2'b11;
                    end
                    OP_LUI: bus.alusrc2 = 2'b11;
                    default: ;
                endcase
            end
            S_MEM: begin
                bus.memread  = is_ld;
                bus.memwrite = is_st;
                bus.memop    = bus.func3;
                bus.pc_write = is_st & done;
            end
            S_WB: begin
                bus.regwrite = 1'b1;
                bus.mem2reg  = is_ld;
                bus.pc_write = 1'b1;
                if (bus.opcode == OP_JAL)       bus.pcsrc = 2'b01;
                else if (bus.opcode == OP_JALR) bus.pcsrc = 2'b11;
            end
            default: ;
        endcase
    end

    assign bus.state   = state_q;
    assign bus.illegal = (state_q == S_TRAP);
endmodule
